wbufifo_arb: RTL and testbench
==============================

WBUFIFO_ARB -- requirements
Module: wbufifo_arb

Interface
REQ-001 SHALL have parameter BW, default 36, giving the codeword width.
REQ-002 SHALL have parameter LGFLEN, default 10, giving the log2 depth of the downstream FIFO, with FLEN = 2^LGFLEN.
REQ-003 SHALL have port i_clk, input, 1 bit, the single clock.
REQ-004 SHALL have port i_rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 SHALL have ports i_a_stb / i_b_stb, inputs, 1 bit each, meaning requester word valid.
REQ-006 SHALL have ports i_a_data / i_b_data, inputs, BW bits each, carrying the requester codeword.
REQ-007 SHALL have ports i_a_last / i_b_last, inputs, 1 bit each, marking the final word of a packet.
REQ-008 SHALL have ports o_a_busy / o_b_busy, outputs, 1 bit each, combinational, meaning the word is not accepted this cycle.
REQ-009 SHALL have port o_fifo_wr, output, 1 bit, the registered FIFO write strobe.
REQ-010 SHALL have port o_fifo_data, output, BW bits, the registered FIFO write data.
REQ-011 SHALL have port i_fifo_rd, input, 1 bit, a FIFO read strobe used for fill tracking.
REQ-012 SHALL have port o_fill, output, LGFLEN bits, the tracked FIFO occupancy.
REQ-013 SHALL have port o_err, output, 1 bit, a registered one-cycle pulse on read-underflow.

Function
REQ-014 SHALL accept a word from requester X in any cycle where i_x_stb=1 and o_x_busy=0.
REQ-015 SHALL present an accepted word on o_fifo_data with o_fifo_wr=1 exactly one cycle after acceptance.
REQ-016 SHALL hold o_fifo_wr=0 and leave o_fifo_data unchanged in all other cycles.
REQ-017 SHALL implement a state machine with the states IDLE, LOCK_A and LOCK_B.
REQ-018 SHALL, in IDLE, grant the single requester when only one strobe is high.
REQ-019 SHALL, in IDLE with both strobes high, grant the requester not served by the last completed packet (round-robin).
REQ-020 SHALL move IDLE->LOCK_X when it accepts an X word with i_x_last=0.
REQ-021 SHALL stay in IDLE when it accepts an X word with i_x_last=1, treating that word as a single-word packet.
REQ-022 SHALL remain in LOCK_X while accepting X words with last=0, keeping the other requester busy throughout.
REQ-023 SHALL move LOCK_X->IDLE when it accepts an X word with i_x_last=1.
REQ-024 SHALL update the round-robin pointer to X on every completed X packet.
REQ-025 SHALL stay in LOCK_X, with no timeout, when i_x_stb drops inside a packet.
REQ-026 SHALL define full as o_fill == FLEN-1, the FIFO capacity.
REQ-027 SHALL, when full, drive both busy outputs to 1, with no acceptance and no state change.
REQ-028 SHALL update the fill counter as o_fill_next = o_fill + accept - dec, where dec = i_fifo_rd && (o_fill != 0).
REQ-029 SHALL let a simultaneous accept and dec leave o_fill unchanged.
REQ-030 SHALL count a word in o_fill from its acceptance cycle, not from when it appears on o_fifo_wr.
REQ-031 SHALL pulse o_err for one cycle in the cycle after i_fifo_rd=1 with o_fill=0 and no accept, leaving o_fill at 0.
REQ-032 SHALL wrap no counter, since o_fill never exceeds FLEN-1.

Reset
REQ-033 SHALL, on i_rst_n=0, immediately (asynchronously) force state=IDLE, round-robin pointer favoring A first, o_fill=0, o_fifo_wr=0, o_fifo_data=0 and o_err=0.
REQ-034 SHALL abandon any packet in progress on reset mid-packet, with no further writes for it.
REQ-035 SHALL release reset synchronously to i_clk as seen by the state registers.

Configuration
REQ-036 SHALL, with WBUFIFO_ARB_PRIORITY_EN defined, resolve IDLE contention with fixed priority to A; the pointer becomes unused and B can be starved.
REQ-037 SHALL, without WBUFIFO_ARB_PRIORITY_EN, use round-robin per REQ-019.
REQ-038 SHALL keep all other behaviour identical in both configurations.

Verification
REQ-039 SHALL be verified by this scenario: A sends 3-word packet 0x1,0x2,0x3(last) while B strobes throughout -> o_fifo_wr high 3 consecutive cycles with 0x1,0x2,0x3; o_b_busy=1 until A's last is accepted; B is served next.
REQ-040 SHALL be verified by this scenario: A and B both present single-word packets (last=1) every cycle from reset -> output order A,B,A,B; with WBUFIFO_ARB_PRIORITY_EN the order is A,A,A,A.
REQ-041 SHALL be verified by this scenario: LGFLEN=2 with A streaming and i_fifo_rd=0 -> exactly 3 words accepted; o_fill=3; both busy stay 1; pulsing i_fifo_rd once gives o_fill=2 and exactly one more acceptance.
REQ-042 SHALL be verified by this scenario: o_fill=0 with i_fifo_rd=1 for one cycle -> o_err=1 for one cycle and o_fill stays 0.
REQ-043 SHALL be verified by this scenario: accept and i_fifo_rd in the same cycle at o_fill=2 -> o_fill stays 2.
REQ-044 SHALL be verified by this scenario: i_rst_n asserted mid-clock after LOCK_B holds 2 of 4 words -> outputs zero immediately; after release B is not locked and A is granted first on contention.

Source files
------------

// File: rtl/wbufifo_arb.sv
// wbufifo_arb: two-requester packet arbiter feeding a downstream FIFO write port.
// Once a packet starts, its requester keeps the port until its last word.
// The arbiter also tracks FIFO occupancy from accepted words and read strobes.
// Define WBUFIFO_ARB_PRIORITY_EN to give A fixed priority on idle contention.
// Without it, contention is resolved round-robin.
//
// state  | meaning
// IDLE   | no packet open; grant by round-robin (or fixed priority to A)
// LOCK_A | A has an open packet; B held busy until A's last word
// LOCK_B | B has an open packet; A held busy until B's last word
module wbufifo_arb #(
   parameter int BW     = 36,
   parameter int LGFLEN = 10
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_a_stb,
   input  logic [BW-1:0]     i_a_data,
   input  logic              i_a_last,
   input  logic              i_b_stb,
   input  logic [BW-1:0]     i_b_data,
   input  logic              i_b_last,
   output logic              o_a_busy,
   output logic              o_b_busy,
   output logic              o_fifo_wr,
   output logic [BW-1:0]     o_fifo_data,
   input  logic              i_fifo_rd,
   output logic [LGFLEN-1:0] o_fill,
   output logic              o_err
);

   typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

   // FLEN-1 is all ones in LGFLEN bits
   localparam logic [LGFLEN-1:0] FILL_MAX = '1;
   localparam logic [LGFLEN-1:0] FILL_ONE = LGFLEN'(1);

   state_t     state;
   logic [1:0] rst_sync;
   logic       rst_int_n;
   logic       a_wins;
   logic       full;
   logic       acc_a;
   logic       acc_b;
   logic       accept;
   logic       dec;

   // Assertion reaches all state immediately; release is retimed to i_clk.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_int_n = rst_sync[1];

`ifdef WBUFIFO_ARB_PRIORITY_EN
   assign a_wins = 1'b1;
`else
   // Set when the last completed packet came from B, so A wins the next contention.
   logic rr_last_b;

   // Round-robin pointer follows the requester of every completed packet.
   always_ff @(posedge i_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         rr_last_b <= 1'b1;
      end else if (acc_a && i_a_last) begin
         rr_last_b <= 1'b0;
      end else if (acc_b && i_b_last) begin
         rr_last_b <= 1'b1;
      end
   end

   assign a_wins = rr_last_b;
`endif

   assign full = (o_fill == FILL_MAX);

   // Busy means "would not be accepted this cycle", independent of the requester's own strobe.
   assign o_a_busy = full || (state == LOCK_B) || ((state == IDLE) && i_b_stb && !a_wins);
   assign o_b_busy = full || (state == LOCK_A) || ((state == IDLE) && i_a_stb && a_wins);

   assign acc_a  = i_a_stb && !o_a_busy;
   assign acc_b  = i_b_stb && !o_b_busy;
   assign accept = acc_a || acc_b;
   assign dec    = i_fifo_rd && (o_fill != '0);

   // Packet lock state plus the registered FIFO write port.
   always_ff @(posedge i_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state       <= IDLE;
         o_fifo_wr   <= 1'b0;
         o_fifo_data <= '0;
      end else begin
         o_fifo_wr <= accept;
         if (acc_a) begin
            o_fifo_data <= i_a_data;
            state       <= i_a_last ? IDLE : LOCK_A;
         end else if (acc_b) begin
            o_fifo_data <= i_b_data;
            state       <= i_b_last ? IDLE : LOCK_B;
         end
      end
   end

   // Occupancy counts words from acceptance; reads of an empty FIFO flag an error.
   always_ff @(posedge i_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         o_fill <= '0;
         o_err  <= 1'b0;
      end else begin
         o_err <= i_fifo_rd && (o_fill == '0) && !accept;
         if (accept && !dec)      o_fill <= o_fill + FILL_ONE;
         else if (!accept && dec) o_fill <= o_fill - FILL_ONE;
      end
   end

endmodule

// File: tb/tb_wbufifo_arb.sv
// Self-checking bench for wbufifo_arb: two instances (default depth and LGFLEN=2)
// share stimulus and are compared each cycle against a packet-level reference model.
module tb_wbufifo_arb;

   localparam int BW = 36;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          a_stb, b_stb, a_last, b_last, fifo_rd;
   logic [BW-1:0] a_data, b_data;

   logic          busy_a[2];
   logic          busy_b[2];
   logic          wr[2];
   logic          err[2];
   logic [BW-1:0] fdata[2];
   logic [9:0]    fill_l;
   logic [1:0]    fill_s;

   int n_checks = 0;
   int n_errors = 0;
   int wr_cnt_s = 0;

   // reference model, one slot per instance
   int            flen[2];
   int            m_owner[2];   // 0 none, 1 A packet open, 2 B packet open
   bit            m_last_b[2];  // last completed packet came from B
   int            m_fill[2];
   bit            m_wr[2];
   logic [BW-1:0] m_data[2];
   bit            m_err[2];
   int            m_hold;
   logic [BW-1:0] exp_order[4];

   wbufifo_arb #(.BW(BW)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_a_stb(a_stb), .i_a_data(a_data), .i_a_last(a_last),
      .i_b_stb(b_stb), .i_b_data(b_data), .i_b_last(b_last),
      .o_a_busy(busy_a[0]), .o_b_busy(busy_b[0]),
      .o_fifo_wr(wr[0]), .o_fifo_data(fdata[0]),
      .i_fifo_rd(fifo_rd), .o_fill(fill_l), .o_err(err[0])
   );

   wbufifo_arb #(.BW(BW), .LGFLEN(2)) dut_s (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_a_stb(a_stb), .i_a_data(a_data), .i_a_last(a_last),
      .i_b_stb(b_stb), .i_b_data(b_data), .i_b_last(b_last),
      .o_a_busy(busy_a[1]), .o_b_busy(busy_b[1]),
      .o_fifo_wr(wr[1]), .o_fifo_data(fdata[1]),
      .i_fifo_rd(fifo_rd), .o_fill(fill_s), .o_err(err[1])
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void model_clear(input int i);
      m_owner[i]  = 0;
      m_last_b[i] = 1'b1;
      m_fill[i]   = 0;
      m_wr[i]     = 1'b0;
      m_data[i]   = '0;
      m_err[i]    = 1'b0;
   endfunction

   // Who gets the port given which requesters are strobing: 0 nobody, 1 A, 2 B.
   function automatic int grant(input int i, input bit a, input bit b);
      int first;
      if (m_fill[i] == flen[i] - 1) return 0;
      if (m_owner[i] == 1) return a ? 1 : 0;
      if (m_owner[i] == 2) return b ? 2 : 0;
`ifdef WBUFIFO_ARB_PRIORITY_EN
      first = 1;
`else
      first = m_last_b[i] ? 1 : 2;
`endif
      if (first == 1) begin
         if (a) return 1;
         if (b) return 2;
      end else begin
         if (b) return 2;
         if (a) return 1;
      end
      return 0;
   endfunction

   function automatic void model_step(input int i);
      int g;
      bit dec;
      bit lst;
      if (!rst_n || m_hold > 0) begin
         model_clear(i);
         return;
      end
      g   = grant(i, a_stb, b_stb);
      dec = fifo_rd && (m_fill[i] > 0);
      m_err[i] = fifo_rd && (m_fill[i] == 0) && (g == 0);
      m_wr[i]  = (g != 0);
      if (g != 0) begin
         m_data[i] = (g == 1) ? a_data : b_data;
         lst       = (g == 1) ? a_last : b_last;
         if (lst) begin
            m_owner[i]  = 0;
            m_last_b[i] = (g == 2);
         end else begin
            m_owner[i] = g;
         end
      end
      m_fill[i] = m_fill[i] + ((g != 0) ? 1 : 0) - (dec ? 1 : 0);
   endfunction

   // Inputs are set at the falling edge; compare, advance the model, wait for next falling edge.
   task automatic tick();
      int fo;
      #1;
      if (!rst_n) begin
         m_hold = 2;
         for (int i = 0; i < 2; i++) model_clear(i);
      end
      for (int i = 0; i < 2; i++) begin
         fo = (i == 0) ? int'(fill_l) : int'(fill_s);
         check($sformatf("busy_a[%0d]", i), 64'(busy_a[i]), 64'(grant(i, 1'b1, b_stb) != 1));
         check($sformatf("busy_b[%0d]", i), 64'(busy_b[i]), 64'(grant(i, a_stb, 1'b1) != 2));
         check($sformatf("wr[%0d]", i),     64'(wr[i]),     64'(m_wr[i]));
         check($sformatf("data[%0d]", i),   64'(fdata[i]),  64'(m_data[i]));
         check($sformatf("fill[%0d]", i),   64'(fo),        64'(m_fill[i]));
         check($sformatf("err[%0d]", i),    64'(err[i]),    64'(m_err[i]));
      end
      if (wr[1] === 1'b1) wr_cnt_s++;
      for (int i = 0; i < 2; i++) model_step(i);
      if (rst_n && m_hold > 0) m_hold--;
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      a_stb = 0; b_stb = 0; a_last = 0; b_last = 0; fifo_rd = 0;
      a_data = '0; b_data = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
      tick();
      tick();
      tick();
   endtask

   initial begin
      flen[0] = 1024;
      flen[1] = 4;
      m_hold  = 2;
      for (int i = 0; i < 2; i++) model_clear(i);
`ifdef WBUFIFO_ARB_PRIORITY_EN
      exp_order = '{36'hA, 36'hA, 36'hA, 36'hA};
`else
      exp_order = '{36'hA, 36'hB, 36'hA, 36'hB};
`endif
      rst_n = 0;
      idle_inputs();
      @(negedge clk);
      do_reset();
      check("reset_fill", 64'(fill_l), 64'd0);
      check("reset_wr",   64'(wr[0]),  64'd0);

      // A sends a 3-word packet while B strobes throughout
      fifo_rd = 1;
      a_stb = 1; a_data = 36'h1; a_last = 0;
      b_stb = 1; b_data = 36'hB0; b_last = 1;
      #1 check("pkt_busy_b0", 64'(busy_b[0]), 64'd1);
      tick();
      a_data = 36'h2;
      #1 check("pkt_busy_b1", 64'(busy_b[0]), 64'd1);
      check("pkt_w1", 64'(fdata[0]), 64'h1);
      tick();
      a_data = 36'h3; a_last = 1;
      #1 check("pkt_busy_b2", 64'(busy_b[0]), 64'd1);
      check("pkt_w2", 64'(fdata[0]), 64'h2);
      tick();
      a_stb = 0;
      #1 check("pkt_busy_b3", 64'(busy_b[0]), 64'd0);
      check("pkt_w3", 64'(fdata[0]), 64'h3);
      check("pkt_wr3", 64'(wr[0]), 64'd1);
      tick();
      b_stb = 0;
      check("pkt_b_next", 64'(fdata[0]), 64'hB0);
      tick();

      // single-word packets from both, every cycle from reset
      do_reset();
      a_stb = 1; a_data = 36'hA; a_last = 1;
      b_stb = 1; b_data = 36'hB; b_last = 1;
      fifo_rd = 1;
      tick();
      for (int k = 0; k < 4; k++) begin
         check($sformatf("order%0d", k), 64'(fdata[0]), 64'(exp_order[k]));
         tick();
      end

      // LGFLEN=2 fills to 3, then one read lets exactly one more in
      do_reset();
      a_stb = 1; a_last = 1; a_data = 36'h55;
      wr_cnt_s = 0;
      for (int k = 0; k < 6; k++) tick();
      check("full_accepts", 64'(wr_cnt_s), 64'd3);
      #1 check("full_fill", 64'(fill_s), 64'd3);
      check("full_busy_a", 64'(busy_a[1]), 64'd1);
      check("full_busy_b", 64'(busy_b[1]), 64'd1);
      fifo_rd = 1;
      tick();
      fifo_rd = 0;
      #1 check("rd_fill", 64'(fill_s), 64'd2);
      check("rd_busy_a", 64'(busy_a[1]), 64'd0);
      wr_cnt_s = 0;
      for (int k = 0; k < 4; k++) tick();
      check("rd_accepts", 64'(wr_cnt_s), 64'd1);

      // simultaneous accept and read at fill 2
      a_stb = 0; fifo_rd = 1;
      tick();
      a_stb = 1;
      tick();
      check("acc_rd_fill", 64'(fill_s), 64'd2);
      a_stb = 0;
      tick();
      tick();
      check("drain_fill", 64'(fill_s), 64'd0);

      // read underflow
      tick();
      check("uf_err", 64'(err[1]), 64'd1);
      check("uf_fill", 64'(fill_s), 64'd0);
      fifo_rd = 0;
      tick();
      check("uf_err_clr", 64'(err[1]), 64'd0);

      // reset in the middle of a B packet
      do_reset();
      b_stb = 1; b_last = 0; b_data = 36'h11;
      tick();
      b_data = 36'h12;
      tick();
      b_data = 36'h13;
      rst_n = 0;
      #1 check("mid_rst_wr", 64'(wr[0]), 64'd0);
      check("mid_rst_data", 64'(fdata[0]), 64'd0);
      check("mid_rst_fill", 64'(fill_l), 64'd0);
      tick();
      rst_n = 1; b_stb = 0;
      tick();
      tick();
      tick();
      a_stb = 1; a_last = 1; a_data = 36'h21;
      b_stb = 1; b_last = 1; b_data = 36'h22;
      #1 check("post_rst_busy_a", 64'(busy_a[0]), 64'd0);
      check("post_rst_busy_b", 64'(busy_b[0]), 64'd1);
      tick();
      tick();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if (!rst_n) rst_n = 1;
         else if ($urandom_range(0, 999) == 0) rst_n = 0;
         a_stb   = ($urandom_range(0, 99) < 60);
         b_stb   = ($urandom_range(0, 99) < 60);
         a_last  = ($urandom_range(0, 99) < 30);
         b_last  = ($urandom_range(0, 99) < 30);
         fifo_rd = ($urandom_range(0, 99) < 45);
         a_data  = {4'($urandom), 32'($urandom)};
         b_data  = {4'($urandom), 32'($urandom)};
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
